// File: rtl/fifo_ctrl32.sv
// -----------------------------------------------------------------------------
// fifo_ctrl32 -- pointer and flag controller for a 32-entry synchronous FIFO.
//
// Converts write/read requests into RAM write strobes and addresses for an
// external single-clock dual-port RAM with a 1-cycle registered read port.
// The block also maintains the registered occupancy, the status flags and the
// sticky overflow/underflow error bits.
//
// Ports:
//   clk           in   1     rising-edge clock
//   clr           in   1     synchronous active-high reset, dominates all inputs
//   wr_en         in   1     write request
//   rd_en         in   1     read request
//   ram_we        out  1     RAM write strobe (wr_en & !full & !clr)
//   ram_waddr     out  AW    RAM write address (write pointer)
//   ram_raddr     out  AW    RAM read address (read pointer)
//   rd_valid      out  1     RAM read data valid (accepted read, delayed 1)
//   count         out  AW+1  registered occupancy, 0..2**AW
//   full          out  1     registered, count == 2**AW
//   empty         out  1     registered, count == 0
//   almost_full   out  1     registered, count >= AFULL_TH
//   almost_empty  out  1     registered, count <= AEMPTY_TH
//   ovf           out  1     sticky: write attempted while full
//   udf           out  1     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_ctrl32 #(
    parameter int AW        = 5,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] DEPTH     = (AW+1)'(2**AW);
    localparam logic [AW:0] AFULL_LV  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LV = (AW+1)'(AEMPTY_TH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wacc;
    logic          racc;
    logic [AW:0]   count_nxt;

    // Acceptance uses only registered flags, so no request can reach a flag
    // combinationally. A write into a full FIFO is refused even when a read
    // frees a slot in the same cycle, and vice versa for an empty FIFO.
    assign wacc = wr_en & ~full;
    assign racc = rd_en & ~empty;

    // clr gates the strobe so the RAM is never written during a reset cycle.
    assign ram_we    = wacc & ~clr;
    assign ram_waddr = wptr;
    assign ram_raddr = rptr;

    always_comb begin
        // NOTE: every path assigns count_nxt because of this default; without
        // it the if/else chain would infer a latch.
        count_nxt = count;
        if (wacc && !racc) begin
            count_nxt = count + 1'b1;
        end else if (racc && !wacc) begin
            count_nxt = count - 1'b1;
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
        end else begin
            // Pointers wrap naturally at 2**AW.
            if (wacc) begin
                wptr <= wptr + 1'b1;
            end
            if (racc) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_nxt;

            // Flags come from the next count so they line up with count.
            full         <= (count_nxt == DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_LV);
            almost_empty <= (count_nxt <= AEMPTY_LV);

            // The RAM registers its output, so data is valid one cycle later.
            rd_valid <= racc;

            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            if (rd_en && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl32.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl32 -- self-checking bench for fifo_ctrl32.
//
// A behavioural model tracks the FIFO as an integer occupancy and a write
// index; the read address is derived as (write index - occupancy) mod 32.
// Directed sequences cover reset, fill, drain, simultaneous boundaries and a
// mid-operation reset, followed by randomized traffic with phase-varying bias.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl32;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          ovf;
    logic          udf;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_cnt   = 0;
    int m_w     = 0;
    bit m_rv    = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;
    bit m_known = 1'b0;

    fifo_ctrl32 #(.AW(AW), .AFULL_TH(28), .AEMPTY_TH(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_raddr    (ram_raddr),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare every
    // output against the model before the rising edge, then advance the model.
    task automatic step(input bit c, input bit w, input bit r);
        bit wa;
        bit ra;
        @(negedge clk);
        clr   = c;
        wr_en = w;
        rd_en = r;
        #1;
        wa = !c && w && (m_cnt < DEPTH);
        ra = !c && r && (m_cnt > 0);
        if (c) begin
            check("ram_we_in_clr", 32'(ram_we), 32'd0);
        end
        if (m_known) begin
            if (!c) begin
                check("ram_we", 32'(ram_we), 32'(wa));
            end
            check("ram_waddr", 32'(ram_waddr), 32'(m_w));
            check("ram_raddr", 32'(ram_raddr), 32'((m_w - m_cnt + DEPTH) % DEPTH));
            check("count", 32'(count), 32'(m_cnt));
            check("full", 32'(full), 32'(m_cnt == DEPTH));
            check("empty", 32'(empty), 32'(m_cnt == 0));
            check("almost_full", 32'(almost_full), 32'(m_cnt >= 28));
            check("almost_empty", 32'(almost_empty), 32'(m_cnt <= 4));
            check("rd_valid", 32'(rd_valid), 32'(m_rv));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("udf", 32'(udf), 32'(m_udf));
        end
        @(posedge clk);
        if (c) begin
            m_cnt   = 0;
            m_w     = 0;
            m_rv    = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_known = 1'b1;
        end else begin
            if (w && m_cnt == DEPTH) m_ovf = 1'b1;
            if (r && m_cnt == 0)     m_udf = 1'b1;
            m_rv  = ra;
            m_cnt = m_cnt + int'(wa) - int'(ra);
            m_w   = (m_w + int'(wa)) % DEPTH;
        end
    endtask

    initial begin
        int pw;
        int pr;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Reset held two cycles with both requests active.
        step(1, 1, 1);
        step(1, 1, 1);

        // Fill, then one write into a full FIFO.
        for (int i = 0; i < 33; i++) step(0, 1, 0);
        // Drain, then one read from an empty FIFO, then idle to see rd_valid drop.
        for (int i = 0; i < 33; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Simultaneous request at full.
        step(1, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 1, 0);
        step(0, 1, 1);
        step(0, 0, 0);

        // Simultaneous request at empty.
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 0, 0);

        // Steady occupancy of 10 while both pointers wrap.
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 1);
        step(0, 0, 0);

        // Reset in the same cycle as a read, after some traffic and errors.
        step(1, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1);
        step(1, 0, 1);
        step(0, 1, 0);
        step(0, 0, 0);

        // Randomized traffic; the bias changes every 200 cycles so both
        // boundaries are reached repeatedly.
        for (int seg = 0; seg < 15; seg++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < pr);
            end
        end
        step(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
